// File: rtl/home_access_pkg.sv
// Shared types and sizing for the door/garage password-check engine.
package home_access_pkg;
   localparam int N_REQ      = 9;
   localparam int PW_W       = 17;
   localparam int GARAGE_IDX = 8;
   localparam int IDX_W      = $clog2(N_REQ);

   typedef logic [PW_W-1:0] pw_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } state_e;
endpackage

// File: rtl/home_access_arbiter_rr.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr,
// wrapping at N (not at a power of two).
module rr_arbiter
   import home_access_pkg::*;
#(
   parameter int N  = N_REQ,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);
   logic [IW:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!valid && eligible[cand[IW-1:0]]) begin
            valid                  = 1'b1;
            idx                    = cand[IW-1:0];
            grant[cand[IW-1:0]]    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/home_access_arbiter.sv
// Shared password store + comparator for the room keypads and the garage:
// round-robin grant, IDLE->CHECK->RESP sequencing, per-requester lockout.
module home_access_arbiter
   import home_access_pkg::*;
#(
   parameter int  MAX_FAIL   = 3,
   parameter int  LOCK_CYC   = 1000,
   parameter pw_t DEFAULT_PW = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        op_change,
   input  logic [N_REQ*PW_W-1:0]   pw_in,
   input  logic [N_REQ*PW_W-1:0]   pw_new,
   output logic [N_REQ-1:0]        ack,
   output logic [N_REQ-1:0]        pass,
   output logic [N_REQ-1:0]        locked_out,
   output logic                    alarm,
   output logic                    busy
);
   localparam int FAIL_W = $clog2(MAX_FAIL+1);
   localparam int TMR_W  = $clog2(LOCK_CYC+1);

   state_e                       state;
   logic [IDX_W-1:0]             rr_ptr, idx, g_idx;
   logic [N_REQ-1:0]             eligible, g_onehot;
   logic                         g_valid;
   pw_t                          pw_q, new_q;
   logic                         chg_q, match_q, resp_vld;
   logic [N_REQ-1:0][PW_W-1:0]   slot;

   assign eligible = req & ~locked_out;
   assign alarm    = |locked_out;
   assign busy     = (state != IDLE);

   rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_rr (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .grant    (g_onehot),
      .idx      (g_idx),
      .valid    (g_valid)
   );

   // idx and match_q stay stable through the edge after RESP, so the
   // registered ack/pass can be built from them with a single flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         idx      <= '0;
         pw_q     <= '0;
         new_q    <= '0;
         chg_q    <= 1'b0;
         match_q  <= 1'b0;
         resp_vld <= 1'b0;
         ack      <= '0;
         pass     <= '0;
      end else begin
         ack      <= '0;
         pass     <= '0;
         resp_vld <= 1'b0;
         if (resp_vld) begin
            ack[idx]  <= 1'b1;
            pass[idx] <= match_q;
         end
         case (state)
            IDLE: if (g_valid) begin
               idx   <= g_idx;
               pw_q  <= pw_in[int'(g_idx)*PW_W +: PW_W];
               new_q <= pw_new[int'(g_idx)*PW_W +: PW_W];
               chg_q <= |(op_change & g_onehot);
               state <= CHECK;
            end
            CHECK: begin
               match_q <= (pw_q == slot[idx]);
               state   <= RESP;
            end
            RESP: begin
               rr_ptr   <= (idx == IDX_W'(N_REQ-1)) ? '0 : idx + 1'b1;
               resp_vld <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_req
      pw_t               slot_r;
      logic [FAIL_W-1:0] fail_cnt;
      logic [TMR_W-1:0]  timer;
      logic              lock_r;
      logic              hit;

      assign hit           = (state == RESP) && (idx == IDX_W'(i));
      assign slot[i]       = slot_r;
      assign locked_out[i] = lock_r;

      // A requester is never granted while locked, so the RESP update
      // and the countdown never contend for the same timer.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            slot_r   <= DEFAULT_PW;
            fail_cnt <= '0;
            timer    <= '0;
            lock_r   <= 1'b0;
         end else begin
            if (timer != '0) begin
               timer <= timer - 1'b1;
               if (timer == TMR_W'(1)) begin
                  lock_r   <= 1'b0;
                  fail_cnt <= '0;
               end
            end
            if (hit) begin
               if (match_q) begin
                  fail_cnt <= '0;
                  if (chg_q) slot_r <= new_q;
               end else if (fail_cnt == FAIL_W'(MAX_FAIL-1)) begin
                  fail_cnt <= FAIL_W'(MAX_FAIL);
                  lock_r   <= 1'b1;
                  timer    <= TMR_W'(LOCK_CYC);
               end else if (fail_cnt < FAIL_W'(MAX_FAIL)) begin
                  fail_cnt <= fail_cnt + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_home_access_arbiter.sv
// Bench for home_access_arbiter: directed op table, hand-timed corner
// sequences, then random traffic against a transaction-level model.
module tb_home_access_arbiter;
   import home_access_pkg::*;

   localparam int MAX_FAIL = 3;
   localparam int LOCK_CYC = 1000;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N_REQ-1:0]      req, op_change;
   logic [N_REQ*PW_W-1:0] pw_in, pw_new;
   logic [N_REQ-1:0]      ack, pass, locked_out;
   logic                  alarm, busy;

   int checks = 0;
   int errors = 0;

   home_access_arbiter #(.MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC), .DEFAULT_PW('0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .op_change  (op_change),
      .pw_in      (pw_in),
      .pw_new     (pw_new),
      .ack        (ack),
      .pass       (pass),
      .locked_out (locked_out),
      .alarm      (alarm),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit chg;
      int pw;
      int pwn;
      bit exp_pass;
      bit exp_lock;
   } vec_t;

   vec_t tbl[15];

   // reference model state
   pw_t              m_slot[N_REQ];
   int               m_fail[N_REQ];
   int               m_timer[N_REQ];
   logic [N_REQ-1:0] m_lock, m_ack, m_pass;
   int               m_phase, m_idx, m_ptr;
   pw_t              m_pw, m_new;
   bit               m_chg, m_match, m_ack_pend, m_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int i, input bit chg, input int pw, input int pwn);
      req[i]                   = 1'b1;
      op_change[i]             = chg;
      pw_in[i*PW_W +: PW_W]    = PW_W'(pw);
      pw_new[i*PW_W +: PW_W]   = PW_W'(pwn);
   endtask

   // one isolated op from IDLE: grant at the first edge, ack three edges later
   task automatic do_op(input int i, input bit chg, input int pw, input int pwn,
                        input bit ep, input bit el, input string nm);
      logic [N_REQ-1:0] e;
      e = '0;
      e[i] = 1'b1;
      @(negedge clk);
      drive(i, chg, pw, pwn);
      @(posedge clk);
      @(negedge clk);
      req[i] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({nm, "_noearly"}, 32'(ack), 32'(0));
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_ack"},  32'(ack), 32'(e));
      chk({nm, "_pass"}, 32'(pass), ep ? 32'(e) : 32'(0));
      chk({nm, "_lock"}, 32'(locked_out[i]), 32'(el));
      chk({nm, "_alarm"}, 32'(alarm), 32'(el));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_REQ; i++) begin
         m_slot[i]  = '0;
         m_fail[i]  = 0;
         m_timer[i] = 0;
      end
      m_lock = '0; m_ack = '0; m_pass = '0;
      m_phase = 0; m_idx = 0; m_ptr = 0;
      m_pw = '0; m_new = '0; m_chg = 0; m_match = 0; m_ack_pend = 0; m_busy = 0;
   endtask

   // one clock edge of the spec-level behaviour: ops take three edges,
   // the result shows one edge after the op finishes
   task automatic model_edge();
      logic [N_REQ-1:0] old_lock;
      bit found;
      int c;
      old_lock = m_lock;
      m_ack = '0;
      m_pass = '0;
      if (m_ack_pend) begin
         m_ack[m_idx]  = 1'b1;
         m_pass[m_idx] = m_match;
         m_ack_pend    = 0;
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (m_timer[i] > 0) begin
            m_timer[i]--;
            if (m_timer[i] == 0) begin
               m_lock[i] = 1'b0;
               m_fail[i] = 0;
            end
         end
      end
      case (m_phase)
         0: begin
            found = 0;
            for (int k = 0; k < N_REQ; k++) begin
               c = (m_ptr + k) % N_REQ;
               if (!found && req[c] && !old_lock[c]) begin
                  found = 1;
                  m_idx = c;
                  m_pw  = pw_in[c*PW_W +: PW_W];
                  m_new = pw_new[c*PW_W +: PW_W];
                  m_chg = op_change[c];
               end
            end
            if (found) m_phase = 1;
         end
         1: m_phase = 2;
         default: begin
            m_match = (m_pw == m_slot[m_idx]);
            if (m_match) begin
               m_fail[m_idx] = 0;
               if (m_chg) m_slot[m_idx] = m_new;
            end else begin
               if (m_fail[m_idx] < MAX_FAIL) m_fail[m_idx]++;
               if (m_fail[m_idx] == MAX_FAIL) begin
                  m_lock[m_idx]  = 1'b1;
                  m_timer[m_idx] = LOCK_CYC;
               end
            end
            m_ptr      = (m_idx + 1) % N_REQ;
            m_ack_pend = 1;
            m_phase    = 0;
         end
      endcase
      m_busy = (m_phase != 0);
   endtask

   initial begin
      logic [N_REQ-1:0] e;
      tbl[0]  = '{1, 1, 0,     78954, 1, 0};
      tbl[1]  = '{1, 0, 78954, 0,     1, 0};
      tbl[2]  = '{1, 0, 45,    0,     0, 0};
      tbl[3]  = '{1, 0, 78954, 0,     1, 0};
      tbl[4]  = '{2, 0, 5,     0,     0, 0};
      tbl[5]  = '{2, 0, 5,     0,     0, 0};
      tbl[6]  = '{2, 0, 0,     0,     1, 0};
      tbl[7]  = '{2, 0, 9,     0,     0, 0};
      tbl[8]  = '{2, 0, 9,     0,     0, 0};
      tbl[9]  = '{3, 1, 4,     99,    0, 0};
      tbl[10] = '{3, 0, 99,    0,     0, 0};
      tbl[11] = '{3, 0, 0,     0,     1, 0};
      tbl[12] = '{8, 0, 7,     0,     0, 0};
      tbl[13] = '{8, 0, 7,     0,     0, 0};
      tbl[14] = '{8, 0, 7,     0,     0, 1};

      rst_n = 1'b0;
      req = '0; op_change = '0; pw_in = '0; pw_new = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack",   32'(ack), 32'(0));
      chk("rst_pass",  32'(pass), 32'(0));
      chk("rst_lock",  32'(locked_out), 32'(0));
      chk("rst_alarm", 32'(alarm), 32'(0));
      chk("rst_busy",  32'(busy), 32'(0));
      rst_n = 1'b1;

      for (int v = 0; v < 15; v++)
         do_op(tbl[v].idx, tbl[v].chg, tbl[v].pw, tbl[v].pwn,
               tbl[v].exp_pass, tbl[v].exp_lock, $sformatf("tbl%0d", v));

      // garage locked: lock set one edge before the third ack
      req[8] = 1'b1; op_change[8] = 1'b0; pw_in[8*PW_W +: PW_W] = '0;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk);
         @(negedge clk);
         chk("locked_noack", 32'(ack), 32'(0));
      end
      req[8] = 1'b0;
      repeat (LOCK_CYC - 12) @(posedge clk);
      @(negedge clk);
      chk("lock_hold",  32'(locked_out), 32'(9'h100));
      chk("alarm_hold", 32'(alarm), 32'(1));
      @(posedge clk);
      @(negedge clk);
      chk("lock_clear",  32'(locked_out), 32'(0));
      chk("alarm_clear", 32'(alarm), 32'(0));

      // simultaneous requesters, rr_ptr = 0 after the garage grant
      @(negedge clk);
      drive(0, 0, 0, 0); drive(5, 0, 0, 0); drive(8, 0, 0, 0);
      for (int t = 1; t <= 14; t++) begin
         @(posedge clk);
         @(negedge clk);
         e = '0;
         if (t == 4 || t == 13) e[0] = 1'b1;
         if (t == 7)  e[5] = 1'b1;
         if (t == 10) e[8] = 1'b1;
         chk($sformatf("rr_ack_t%0d", t),  32'(ack),  32'(e));
         chk($sformatf("rr_pass_t%0d", t), 32'(pass), 32'(e));
         if (t == 7) req[5] = 1'b0;
         if (t == 10) begin req[8] = 1'b0; req[0] = 1'b0; end
      end

      // reset during CHECK of a change op
      @(negedge clk);
      drive(4, 1, 0, 555);
      @(posedge clk);
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'(1));
      rst_n = 1'b0;
      req = '0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_ack",  32'(ack), 32'(0));
      rst_n = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(posedge clk);
         @(negedge clk);
         chk("post_rst_noack", 32'(ack), 32'(0));
      end
      do_op(4, 0, 0, 0, 1, 0, "slot4_default");
      do_op(1, 0, 0, 0, 1, 0, "slot1_default");

      // random traffic against the model
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < N_REQ; i++) begin
            req[i]                 = ($urandom_range(0, 3) == 0);
            op_change[i]           = ($urandom_range(0, 3) == 0);
            pw_in[i*PW_W +: PW_W]  = PW_W'($urandom_range(0, 2));
            pw_new[i*PW_W +: PW_W] = PW_W'($urandom_range(0, 2));
         end
         @(posedge clk);
         model_edge();
         @(negedge clk);
         chk("rnd_ack",   32'(ack), 32'(m_ack));
         chk("rnd_pass",  32'(pass), 32'(m_pass));
         chk("rnd_lock",  32'(locked_out), 32'(m_lock));
         chk("rnd_alarm", 32'(alarm), 32'(|m_lock));
         chk("rnd_busy",  32'(busy), 32'(m_busy));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
